cici_sched: RTL
===============

# cici_sched

Sequencing controller for the CIC interpolator chain. It accepts low-rate input samples over a valid/ready handshake and tracks the interpolation phase. It also generates the clock-enable strobes: a comb enable at the low rate, an integrator and upsample enable at the high rate, and a load strobe for the zero-insertion upsampler. It handles start-up priming, underflow zero-stuffing and a controlled drain on stop, so the datapath blocks need only plain `i_ena` inputs.

## Interface

Parameters:
- gp_data_width, 8, sample bit-width (signed, passed through).
- gp_rate_width, 4, width of the interpolation-factor field.
- gp_latency, 4, number of low-rate periods needed to fill the comb/integrator pipeline.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_an  input  1  reset; synchronous, active-low.
- i_tick  input  1  high-rate sample strobe; all sequencing advances only when it is 1.
- i_start  input  1  start request; honoured only in IDLE.
- i_stop  input  1  stop request; honoured in PRIME and RUN.
- i_rate  input  gp_rate_width  interpolation factor R; latched at start.
- i_data  input  gp_data_width  input sample.
- i_valid  input  1  i_data valid.
- o_ready  output  1  block can accept a sample this cycle.
- o_data  output  gp_data_width  sample presented to the comb section.
- o_ena_comb  output  1  comb-section enable (low rate).
- o_ena_intg  output  1  upsampler/integrator enable (high rate).
- o_load  output  1  phase-0 strobe; the upsampler loads o_data.
- o_phase  output  gp_rate_width  current phase, 0..R-1.
- o_out_valid  output  1  the chain output is valid this high-rate tick.
- o_busy  output  1  state is not IDLE.
- o_underflow  output  1  one-cycle pulse when phase 0 finds no buffered sample in RUN.

## Operation

State machine:
- **IDLE.**
  - i_start=1 with i_rate>=2: latch r_rate=i_rate, set phase to 0, go to PRIME.
  - i_start with i_rate<2: ignored.
- **PRIME.**
  - Count phase-0 ticks.
  - After gp_latency phase-0 ticks, go to RUN.
  - i_stop: go to DRAIN.
- **RUN.** Normal operation. i_stop goes to DRAIN.
- **DRAIN.**
  - o_ready=0.
  - Feed zeros for gp_latency phase-0 ticks, then go to IDLE.
  - Any buffered sample is discarded on entry.

Phase counter:
- Active in PRIME, RUN and DRAIN.
- On i_tick, phase goes from r_rate-1 back to 0, otherwise phase+1.
- Holds when i_tick=0.

Input buffer:
- One entry.
- o_ready = (PRIME or RUN) and (buffer empty or a consume happens this cycle).
- A transfer happens when i_valid and o_ready are both 1.
- A consume happens on an i_tick cycle with phase==0 in PRIME or RUN.
- A transfer and a consume in the same cycle leave the buffer full with the new sample.

Strobes (combinational from the registered state):
- o_ena_intg = i_tick and state is not IDLE.
- o_load = o_ena_comb = i_tick and phase==0 and state is not IDLE.
- o_data = buffer contents if the buffer is full and the state is PRIME or RUN; otherwise 0.

Underflow:
- In RUN, a consume with the buffer empty presents zero, still asserts o_ena_comb, and pulses o_underflow.
- In PRIME and DRAIN, an empty buffer is not an underflow.

Output valid: o_out_valid = i_tick and state==RUN.

Start/stop priority: i_stop has priority over i_start. i_start outside IDLE is ignored.

## Timing

- Reset (i_rst_an=0 sampled on a rising edge) forces:
  - state IDLE, phase 0, buffer empty, r_rate 0;
  - all outputs 0 and o_data 0.
- Reset mid-operation aborts immediately with no drain.
- Strobes have zero-cycle latency from i_tick.
- State, phase and buffer update on the clock edge of the i_tick cycle.
- Start: the first o_load comes on the first i_tick after the edge that latched i_start, with o_phase=0.
- First o_out_valid: on the first i_tick after gp_latency·R ticks of PRIME.
- Stop: DRAIN lasts gp_latency phase-0 ticks. o_busy falls on the edge after the last one.
- An i_rate change outside IDLE has no effect.

## Configuration

CICI_SCHED_UNDERFLOW_CNT_EN:
- When defined: adds output o_underflow_cnt (16 bits). It increments on each o_underflow pulse, saturates at 0xFFFF, clears on an accepted start and on reset.
- When undefined: the port and the counter are absent and all other behaviour is identical.

## Test plan

- Reset held 3 cycles mid-RUN → all outputs 0 on the next cycle, o_busy=0, o_phase=0.
- R=4, gp_latency=4, i_tick every cycle, i_valid always 1 with an incrementing sample →
  - o_load on ticks 0,4,8,…;
  - o_ready 1 per period;
  - first o_out_valid on tick 16;
  - o_data matches the samples in order.
- R=3, i_tick every 2nd cycle → phase advances only on ticks; o_ena_comb every 6 cycles.
- RUN with i_valid withheld over one phase-0 tick → o_data=0, o_ena_comb=1, o_underflow pulses once (counter =1 when the macro is defined).
- i_stop and i_start together in RUN → DRAIN entered; o_ready=0; exactly 4 zero loads; then IDLE.
- i_start with i_rate=1 → stays IDLE, o_busy=0.

Source files
------------

// File: rtl/cici_sched_if.sv
// Handshake and strobe bundle between the CIC interpolator datapath and its sequencer.
// Latency: none, wires only.
// Backpressure: o_ready/i_valid carry sample flow control; CICI_SCHED_UNDERFLOW_CNT_EN adds o_underflow_cnt.
interface cici_sched_if #(
   parameter int gp_data_width = 8,
   parameter int gp_rate_width = 4
);
   logic                     i_tick;
   logic                     i_start;
   logic                     i_stop;
   logic [gp_rate_width-1:0] i_rate;
   logic [gp_data_width-1:0] i_data;
   logic                     i_valid;
   logic                     o_ready;
   logic [gp_data_width-1:0] o_data;
   logic                     o_ena_comb;
   logic                     o_ena_intg;
   logic                     o_load;
   logic [gp_rate_width-1:0] o_phase;
   logic                     o_out_valid;
   logic                     o_busy;
   logic                     o_underflow;
`ifdef CICI_SCHED_UNDERFLOW_CNT_EN
   logic [15:0]              o_underflow_cnt;
`endif

   modport slave (
`ifdef CICI_SCHED_UNDERFLOW_CNT_EN
      output o_underflow_cnt,
`endif
      input  i_tick, i_start, i_stop, i_rate, i_data, i_valid,
      output o_ready, o_data, o_ena_comb, o_ena_intg, o_load, o_phase,
      output o_out_valid, o_busy, o_underflow
   );

   modport master (
`ifdef CICI_SCHED_UNDERFLOW_CNT_EN
      input  o_underflow_cnt,
`endif
      output i_tick, i_start, i_stop, i_rate, i_data, i_valid,
      input  o_ready, o_data, o_ena_comb, o_ena_intg, o_load, o_phase,
      input  o_out_valid, o_busy, o_underflow
   );
endinterface

// File: rtl/cici_sched.sv
// Sequencer for the CIC interpolator: phase tracking, enable strobes, priming, underflow stuffing, drain.
// Latency: strobes are combinational from i_tick; state/phase/buffer move on the edge of a tick cycle.
// Backpressure: one-entry sample buffer, o_ready while buffer empty or being consumed; optional CICI_SCHED_UNDERFLOW_CNT_EN counter.
module cici_sched #(
   parameter int gp_data_width = 8,
   parameter int gp_rate_width = 4,
   parameter int gp_latency    = 4
) (
   input logic          i_clk,
   input logic          i_rst_an,
   cici_sched_if.slave  bus
);
   localparam int cw = $clog2(gp_latency + 1);

   typedef enum logic [1:0] {st_idle, st_prime, st_run, st_drain} state_t;

   state_t                   state;
   logic [gp_rate_width-1:0] rate;
   logic [gp_rate_width-1:0] phase;
   logic [cw-1:0]            cnt;
   logic                     full;
   logic [gp_data_width-1:0] smp;

   logic active;
   logic busy;
   logic ph0;
   logic last_ph;
   logic consume;
   logic ready;
   logic xfer;
   logic start_ok;

   assign active   = (state == st_prime) || (state == st_run);
   assign busy     = (state != st_idle);
   assign ph0      = (phase == '0);
   assign last_ph  = (phase == rate - gp_rate_width'(1));
   assign consume  = bus.i_tick && ph0 && active;
   assign ready    = active && (!full || consume);
   assign xfer     = bus.i_valid && ready;
   assign start_ok = (state == st_idle) && bus.i_start && (bus.i_rate >= gp_rate_width'(2));

   // Sequencer state, phase counter, prime/drain period counter and the one-entry sample buffer.
   always_ff @(posedge i_clk) begin
      if (!i_rst_an) begin
         state <= st_idle;
         rate  <= '0;
         phase <= '0;
         cnt   <= '0;
         full  <= 1'b0;
         smp   <= '0;
      end else begin
         if (xfer) begin
            full <= 1'b1;
            smp  <= bus.i_data;
         end else if (consume) begin
            full <= 1'b0;
         end

         if (bus.i_tick && busy) begin
            phase <= last_ph ? '0 : phase + gp_rate_width'(1);
         end

         case (state)
            st_idle: begin
               if (start_ok) begin
                  state <= st_prime;
                  rate  <= bus.i_rate;
                  phase <= '0;
                  cnt   <= '0;
               end
            end
            st_prime, st_run: begin
               if (bus.i_stop) begin
                  // The drain feeds zeros, so whatever is buffered is dropped now.
                  state <= st_drain;
                  cnt   <= '0;
                  full  <= 1'b0;
               end else if (bus.i_tick && state == st_prime) begin
                  if (ph0) cnt <= cnt + cw'(1);
                  // Leave priming at the end of the last full low-rate period.
                  if (last_ph && cnt == cw'(gp_latency)) state <= st_run;
               end
            end
            st_drain: begin
               if (bus.i_tick && ph0) begin
                  if (cnt == cw'(gp_latency - 1)) begin
                     state <= st_idle;
                     phase <= '0;
                  end else begin
                     cnt <= cnt + cw'(1);
                  end
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

`ifdef CICI_SCHED_UNDERFLOW_CNT_EN
   logic [15:0] ucnt;

   // Saturating count of underflow pulses, cleared by an accepted start.
   always_ff @(posedge i_clk) begin
      if (!i_rst_an) begin
         ucnt <= '0;
      end else if (start_ok) begin
         ucnt <= '0;
      end else if (bus.o_underflow && ucnt != 16'hFFFF) begin
         ucnt <= ucnt + 16'd1;
      end
   end

   assign bus.o_underflow_cnt = ucnt;
`endif

   assign bus.o_ready     = ready;
   assign bus.o_data      = (full && active) ? smp : '0;
   assign bus.o_ena_intg  = bus.i_tick && busy;
   assign bus.o_load      = bus.i_tick && busy && ph0;
   assign bus.o_ena_comb  = bus.i_tick && busy && ph0;
   assign bus.o_phase     = phase;
   assign bus.o_out_valid = bus.i_tick && (state == st_run);
   assign bus.o_busy      = busy;
   assign bus.o_underflow = consume && (state == st_run) && !full;
endmodule
